// File: rtl/gate_chain_pkg.sv
// Shared op encoding, reset defaults and the bitwise op evaluator
// for the pipelined gate chain.
package gate_chain_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_NAND = 3'd1,
        OP_OR   = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_PASS = 3'd6,
        OP_INV  = 3'd7
    } op_e;

    localparam op_e OP_RST_STAGE0 = OP_AND;
    localparam op_e OP_RST_OTHER  = OP_NAND;

    // Callers zero-extend into this width and truncate the result back.
    localparam int OP_MAX_W = 64;

    function automatic logic [OP_MAX_W-1:0] apply_op(
        input op_e                 op,
        input logic [OP_MAX_W-1:0] acc,
        input logic [OP_MAX_W-1:0] b
    );
        logic [OP_MAX_W-1:0] r;
        case (op)
            OP_AND:  r = acc & b;
            OP_NAND: r = ~(acc & b);
            OP_OR:   r = acc | b;
            OP_NOR:  r = ~(acc | b);
            OP_XOR:  r = acc ^ b;
            OP_XNOR: r = ~(acc ^ b);
            OP_PASS: r = acc;
            default: r = ~acc;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_chain_stage.sv
// One register slice of the chain: valid, accumulator and the operand
// slices still owed to downstream stages.
module gate_chain_stage
    import gate_chain_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NOPS  = 0,
    localparam int OPW   = (NOPS > 0) ? NOPS * WIDTH : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      src_valid,
    input  logic [WIDTH-1:0]          src_acc,
    input  logic [(NOPS+1)*WIDTH-1:0] src_ops,
    input  op_e                       op,
    input  logic                      ready,
    input  logic                      dst_ready,
    output logic                      valid,
    output logic [WIDTH-1:0]          acc,
    output logic [OPW-1:0]            carry
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [OPW-1:0]   carry_q, carry_d, carry_in;
    logic             take;

    // Slice 0 is consumed here; the rest rides along with the beat.
    if (NOPS > 0) begin : g_carry
        always_comb carry_in = src_ops[(NOPS+1)*WIDTH-1:WIDTH];
    end else begin : g_nocarry
        always_comb carry_in = '0;
    end

    assign take = src_valid && ready;

    always_comb begin
        valid_d = valid_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        if (take) begin
            valid_d = 1'b1;
            acc_d   = WIDTH'(apply_op(op, OP_MAX_W'(src_acc),
                                      OP_MAX_W'(src_ops[WIDTH-1:0])));
            carry_d = carry_in;
        end else if (dst_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            acc_q   <= '0;
            carry_q <= '0;
        end else begin
            valid_q <= valid_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end

    assign valid = valid_q;
    assign acc   = acc_q;
    assign carry = carry_q;

endmodule

// File: rtl/gate_chain_pipe.sv
// STAGES-deep valid/ready pipelined bitwise chain with a run-time
// programmable op per stage.
module gate_chain_pipe
    import gate_chain_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 3,
    parameter int IDXW   = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_a,
    input  logic [STAGES*WIDTH-1:0] in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    input  logic                    cfg_we,
    input  logic [IDXW-1:0]         cfg_idx,
    input  logic [2:0]              cfg_op,
    output logic                    busy
);

    // Stage i consumes (STAGES-i) operand slices; segments are packed back to back.
    function automatic int seg_off(input int i);
        return WIDTH * (i * STAGES - (i * (i - 1)) / 2);
    endfunction

    localparam int OPS_BITS = seg_off(STAGES);

    logic [STAGES-1:0]            vld;
    logic [STAGES-1:0][WIDTH-1:0] acc;
    logic [STAGES:0]              rdy;
    logic [OPS_BITS-1:0]          ops_bus;
    op_e                          op_q [STAGES];
    op_e                          op_d [STAGES];

    // Combinational ready chain so a released stall shifts every stage at once.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--)
            rdy[i] = !vld[i] || rdy[i+1];
    end

    assign ops_bus[seg_off(0) +: STAGES*WIDTH] = in_b;

    for (genvar i = 0; i < STAGES; i++) begin : g_st
        localparam int NOPS = STAGES - 1 - i;
        localparam int OPW  = (NOPS > 0) ? NOPS * WIDTH : 1;

        logic             src_valid;
        logic [WIDTH-1:0] src_acc;
        logic [OPW-1:0]   carry;

        if (i == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_acc   = in_a;
        end else begin : g_body
            assign src_valid = vld[i-1];
            assign src_acc   = acc[i-1];
        end

        if (NOPS > 0) begin : g_fwd
            assign ops_bus[seg_off(i+1) +: NOPS*WIDTH] = carry;
        end else begin : g_tail
            logic carry_unused;
            assign carry_unused = carry[0];
        end

        gate_chain_stage #(
            .WIDTH (WIDTH),
            .NOPS  (NOPS)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .src_valid (src_valid),
            .src_acc   (src_acc),
            .src_ops   (ops_bus[seg_off(i) +: (NOPS+1)*WIDTH]),
            .op        (op_q[i]),
            .ready     (rdy[i]),
            .dst_ready (rdy[i+1]),
            .valid     (vld[i]),
            .acc       (acc[i]),
            .carry     (carry)
        );
    end

    // Out-of-range indices match no stage and are dropped.
    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            op_d[s] = op_q[s];
            if (cfg_we && (32'(cfg_idx) == 32'(s)))
                op_d[s] = op_e'(cfg_op);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++)
                op_q[s] <= (s == 0) ? OP_RST_STAGE0 : OP_RST_OTHER;
        end else begin
            for (int s = 0; s < STAGES; s++)
                op_q[s] <= op_d[s];
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld[STAGES-1];
    assign out_data  = acc[STAGES-1];
    assign busy      = |vld;

endmodule

// File: tb/tb_gate_chain_pipe.sv
// Scoreboard bench for gate_chain_pipe: the driver pushes model results on
// acceptance, an independent monitor pops and compares on each output beat.
module tb_gate_chain_pipe;

    localparam int W  = 8;
    localparam int S  = 3;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid, in_ready, out_valid, out_ready, cfg_we, busy;
    logic [W-1:0]   in_a, out_data;
    logic [S*W-1:0] in_b;
    logic [IW-1:0]  cfg_idx;
    logic [2:0]     cfg_op;

    int          checks = 0;
    int          passes = 0;
    logic [7:0]  exp_q[$];
    int          mops[S];
    logic        rnd_bp = 1'b0;
    logic        stall_prev = 1'b0;
    logic [7:0]  stall_data;

    always #5 clk = ~clk;

    gate_chain_pipe #(.WIDTH(W), .STAGES(S), .IDXW(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_op    (cfg_op),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: fold the operands left to right through the op table.
    function automatic logic [7:0] model(input logic [7:0] a, input logic [23:0] b, input int ops[S]);
        logic [7:0] r;
        logic [7:0] x;
        r = a;
        for (int i = 0; i < S; i++) begin
            x = b[i*8 +: 8];
            case (ops[i])
                0: r = r & x;
                1: r = ~(r & x);
                2: r = r | x;
                3: r = ~(r | x);
                4: r = r ^ x;
                5: r = ~(r ^ x);
                6: r = r;
                default: r = ~r;
            endcase
        end
        return r;
    endfunction

    task automatic send(input logic [7:0] a, input logic [23:0] b, input logic [7:0] exp);
        in_a = a; in_b = b; in_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(exp);
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        checks++;
        $display("FAIL accept_timeout: in_ready stayed 0 for 200 cycles");
    endtask

    task automatic drain();
        int c;
        in_valid = 1'b0; rnd_bp = 1'b0; out_ready = 1'b1;
        c = 0;
        while ((exp_q.size() != 0 || busy) && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        checks++;
        if (c < 100) passes++;
        else $display("FAIL drain_timeout: pending=%0d busy=%0b after 100 cycles", exp_q.size(), busy);
    endtask

    task automatic cfg_write(input int idx, input int op);
        cfg_we = 1'b1; cfg_idx = idx[IW-1:0]; cfg_op = op[2:0];
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (idx < S) mops[idx] = op;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev && out_valid) check("stall_hold", out_data, stall_data);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_output: got 0x%0h with nothing expected", out_data);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                end
            end
            stall_prev <= out_valid && !out_ready;
            stall_data <= out_data;
        end
    end

    initial begin
        logic [7:0]  a, ea, eb, ec, ed, ex;
        logic [23:0] b;
        int          ops_or[S];

        in_valid = 0; in_a = '0; in_b = '0; out_ready = 1'b1;
        cfg_we = 0; cfg_idx = '0; cfg_op = '0;
        mops = '{0, 1, 1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency: three register stages.
        a = 8'($urandom); b = 24'($urandom);
        send(a, b, model(a, b, mops));
        in_valid = 1'b0;
        check("lat_edge0", out_valid, 0);
        @(posedge clk); #1;
        check("lat_edge1", out_valid, 0);
        @(posedge clk); #1;
        check("lat_edge2", out_valid, 1);
        drain();

        // Legacy ~(~(A&B&C)&D), every bit lane carrying the same pattern.
        for (int x = 0; x < 16; x++) begin
            ea = {8{x[0]}}; eb = {8{x[1]}}; ec = {8{x[2]}}; ed = {8{x[3]}};
            ex = ~(~(ea & eb & ec) & ed);
            send(ea, {ed, ec, eb}, ex);
        end
        drain();

        // Random stream with random back-pressure, default ops.
        rnd_bp = 1'b1;
        for (int n = 0; n < 30; n++) begin
            a = 8'($urandom); b = 24'($urandom);
            send(a, b, model(a, b, mops));
        end
        drain();

        // Directed stall: fill, hold 5 cycles, release.
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            a = 8'($urandom); b = 24'($urandom);
            send(a, b, model(a, b, mops));
        end
        a = 8'($urandom); b = 24'($urandom);
        in_a = a; in_b = b; in_valid = 1'b1;
        check("full_in_ready", in_ready, 0);
        check("full_busy", busy, 1);
        repeat (5) @(posedge clk);
        #1;
        check("stalled_out_valid", out_valid, 1);
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        send(a, b, model(a, b, mops));
        for (int n = 0; n < 6; n++) begin
            a = 8'($urandom); b = 24'($urandom);
            send(a, b, model(a, b, mops));
        end
        drain();

        // Config: op[1]=XOR, op[2]=PASS, out-of-range write ignored.
        cfg_write(1, 4);
        cfg_write(2, 6);
        cfg_write(3, 7);
        send(8'hF0, {8'($urandom), 8'h3C, 8'hFF}, 8'hCC);
        rnd_bp = 1'b1;
        for (int n = 0; n < 10; n++) begin
            a = 8'($urandom); b = 24'($urandom);
            send(a, b, model(a, b, mops));
        end
        drain();
        cfg_write(1, 1);
        cfg_write(2, 1);

        // Mid-flight reconfig: X already past stage 1 keeps NAND, Y gets OR.
        send(8'hFF, 24'hFFFFFF, model(8'hFF, 24'hFFFFFF, mops));
        in_valid = 1'b0;
        @(posedge clk); #1;
        ops_or = mops; ops_or[1] = 2;
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_op = 3'd2;
        send(8'hFF, 24'hFFFFFF, model(8'hFF, 24'hFFFFFF, ops_or));
        cfg_we = 1'b0;
        mops[1] = 2;
        a = 8'($urandom); b = 24'($urandom);
        send(a, b, model(a, b, mops));
        drain();

        // Asynchronous reset with a full, stalled pipeline.
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            a = 8'($urandom); b = 24'($urandom);
            send(a, b, model(a, b, mops));
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 1);
        exp_q.delete();
        mops = '{0, 1, 1};
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", busy, 0);
        send(8'hFF, 24'hFFFFFF, 8'hFF);
        for (int n = 0; n < 5; n++) begin
            a = 8'($urandom); b = 24'($urandom);
            send(a, b, model(a, b, mops));
        end
        drain();

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/gate_chain_pipe.md
# gate_chain_pipe

Parametrised, pipelined successor to the team's fixed AND/NAND gate chain. It is a STAGES-deep, WIDTH-bit logic chain. Each stage combines a running accumulator with its own operand using a run-time-selectable bitwise op, then registers the result. Stages move data with valid/ready handshakes, so the block can sit between any streaming producer and consumer. With reset-default ops, STAGES=3 and WIDTH=1, it computes the legacy function ~(~(A&B&C)&D), one result per cycle after the pipeline fills.

## Interface
- WIDTH, 8, bit width of accumulator and of each operand
- STAGES, 3, number of chain stages (≥1); also the pipeline latency
- IDXW, $clog2(STAGES) (min 1), width of cfg_idx
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_a  in  WIDTH  chain seed (accumulator initial value)
- in_b  in  STAGES*WIDTH  operands; slice [i*WIDTH +: WIDTH] is used by stage i
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  WIDTH  chain result
- cfg_we  in  1  op-table write strobe
- cfg_idx  in  IDXW  stage index to write
- cfg_op  in  3  op code to write
- busy  out  1  any stage holds a valid beat

## Operation
- Op codes:
  - 0 AND: acc&b
  - 1 NAND: ~(acc&b)
  - 2 OR
  - 3 NOR
  - 4 XOR
  - 5 XNOR
  - 6 PASS: acc
  - 7 INV: ~acc
- Op table: one 3-bit register per stage.
  - Reset values: stage 0 = AND, all other stages = NAND.
  - Write: when cfg_we=1 and cfg_idx<STAGES, op[cfg_idx] <= cfg_op.
  - cfg_idx≥STAGES is ignored with no side effect.
- Stage i register holds: valid_i, acc_i (WIDTH), and the operand slices for stages i+1..STAGES-1.
  - Operands travel with their beat. in_b is sampled only on acceptance.
- Transfer into stage i:
  - Source is the input for i=0, otherwise stage i-1.
  - Occurs when the source is valid and ready_i = !valid_i || ready_{i+1}.
  - ready_STAGES = out_ready.
  - New acc_i = op[i](source acc, operand_i), using the op-table value held at the start of that cycle.
- Outputs:
  - in_ready = ready_0.
  - out_valid = valid_{STAGES-1}.
  - out_data = acc_{STAGES-1}.
  - busy = OR of all valid_i.
- A stage with no transfer in and no transfer out holds its contents. Beats are never dropped or duplicated, and order is preserved.

## Timing
- Reset (async assert, sync deassert by system):
  - All valid_i=0 and all acc/operand registers=0.
  - Op table returns to defaults.
  - in_ready=1, out_valid=0, out_data=0, busy=0.
  - Reset mid-stream discards every in-flight beat.
- Latency: a beat accepted at edge k appears with out_valid=1 after edge k+STAGES-1, i.e. STAGES register stages.
- Throughput: one beat per cycle while out_ready=1.
- Full pipeline with out_ready=0: in_ready=0, all registers hold, and out_data stays stable.
- Back-pressure release: in the same cycle out_ready rises, every stage shifts and in_ready=1 (combinational ready chain).
- Producer obligation: in_valid, in_a and in_b are held until acceptance.
- cfg write in cycle k: affects only transfers on edges after k. A beat entering stage i on edge k uses the old op[i]. Beats already past stage i are unaffected.
- Simultaneous cfg write and stall: legal. The stalled beat keeps its already-computed acc.

## Structure
- Package gate_chain_pkg:
  - op_e enum (3-bit codes above).
  - Function apply_op(op_e, acc, b), WIDTH-generic via parameterised use.
  - Constant OP_RST_STAGE0=AND and OP_RST_OTHER=NAND.
- Sub-module gate_chain_stage: one register slice holding valid/acc/operand payload, with ready logic. Instantiated STAGES times in a generate loop. The top level holds the op table, cfg decode and busy.

## Test plan
- Legacy equivalence: WIDTH=1, STAGES=3, default ops. Sweep all 16 combinations (A=in_a, B,C,D=in_b[0..2]) back-to-back with out_ready=1. out_data must equal ~(~(A&B&C)&D) three cycles after each accept, e.g. A=B=C=1, D=1 → 1; A=0, D=1 → 0.
- Config: WIDTH=8. Write op[1]=XOR and op[2]=PASS. Beat a=0xF0, b0=0xFF, b1=0x3C → out_data=0xCC. Write cfg_idx=3 (out of range) → table unchanged.
- Back-pressure: stream 10 beats, hold out_ready=0 for 5 cycles mid-stream. Required: in_ready=0 once STAGES beats are in flight, out_data stable while stalled, all 10 results in order, no loss or duplicates.
- Mid-flight reconfig: with beats in stages 0 and 1, write op[1]=OR. The beat already in stage 1 keeps the NAND result; the next beat uses OR.
- Reset mid-operation: assert rst_n=0 asynchronously with a full pipeline. Outputs go immediately to out_valid=0, out_data=0, busy=0, in_ready=1. The op table reads back the defaults via behaviour: after release, A=B=C=D=1 → 1.
